// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - next-PC select encodings and default vectors
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_REG    = 3'd3,
    SRC_RET    = 3'd4,
    SRC_EXC    = 3'd5,
    SRC_HOLD   = 3'd6
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

  // Sources whose target is alignment-checked and which may touch the RAS.
  function automatic logic is_flow_src(input logic [2:0] src);
    return src <= 3'(SRC_RET);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_RAS_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] top_idx;
  logic             pop_ok;

  assign top_idx = sp_q - PTR_W'(1);
  assign pop_ok  = pop && (count_q != '0);
  assign top     = entries_q[top_idx];
  assign count   = count_q;

  always_comb begin
    entries_d = entries_q;
    sp_d      = sp_q;
    count_d   = count_q;
    if (pop_ok && push) begin
      // Pop-then-push collapses to replacing the top in place.
      entries_d[top_idx] = push_data;
    end else if (pop_ok) begin
      sp_d    = top_idx;
      count_d = count_q - CNT_W'(1);
    end else if (push) begin
      // When full, sp already points at the oldest entry, so it is overwritten.
      entries_d[sp_q] = push_data;
      sp_d            = sp_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, epc and next-PC selection with RAS
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pc_write,
  input  logic [2:0]                   pc_src,
  input  logic [WIDTH-1:0]             branch_target,
  input  logic [WIDTH-1:0]             jump_target,
  input  logic [WIDTH-1:0]             reg_target,
  input  logic                         call,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [WIDTH-1:0]             epc,
  output logic                         misaligned,
  output logic                         ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             misaligned_q, misaligned_d;
  logic             ras_underflow_q, ras_underflow_d;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic             ret_empty;
  logic             bad_align;
  logic             ras_push;
  logic             ras_pop;

  assign pc_plus4 = pc_q + WIDTH'(4);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_comb begin
    target    = pc_q;
    ret_empty = 1'b0;
    case (pc_src)
      SRC_SEQ:    target = pc_plus4;
      SRC_BRANCH: target = branch_target;
      SRC_JUMP:   target = jump_target;
      SRC_REG:    target = reg_target;
      SRC_RET: begin
        // An empty stack falls back to the register target.
        if (ras_count != '0) begin
          target = ras_top;
        end else begin
          target    = reg_target;
          ret_empty = 1'b1;
        end
      end
      SRC_EXC:    target = EXC_VECTOR;
      default:    target = pc_q;
    endcase
  end

  assign bad_align = is_flow_src(pc_src) && (target[1:0] != 2'b00);
  assign ras_push  = pc_write && call && is_flow_src(pc_src);
  assign ras_pop   = pc_write && (pc_src == SRC_RET);

  always_comb begin
    pc_d            = pc_q;
    epc_d           = epc_q;
    misaligned_d    = 1'b0;
    ras_underflow_d = 1'b0;
    if (pc_write) begin
      if ((pc_src == SRC_EXC) || bad_align) begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
      end else begin
        pc_d = target;
      end
      misaligned_d    = bad_align;
      ras_underflow_d = ret_empty;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_VECTOR;
      epc_q           <= '0;
      misaligned_q    <= 1'b0;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      epc_q           <= epc_d;
      misaligned_q    <= misaligned_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign misaligned    = misaligned_q;
  assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed checks against a queue-based model
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'h180;

  logic        clock;
  logic        reset;
  logic        pc_write;
  logic [2:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] reg_target;
  logic        call;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        misaligned;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_mis;
  logic        m_unf;
  logic [31:0] m_ras [$];

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .call          (call),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .misaligned    (misaligned),
    .ras_underflow (ras_underflow),
    .ras_count     (ras_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_mis = 1'b0;
    m_unf = 1'b0;
    m_ras.delete();
  endtask

  // Stack modelled as an unbounded queue trimmed from the oldest end.
  task automatic model_step(input logic w, input logic [2:0] s, input logic [31:0] bt,
                            input logic [31:0] jt, input logic [31:0] rt, input logic c);
    logic [31:0] plus4, nxt;
    logic        unf, mis, flow;
    if (!w) begin
      m_mis = 1'b0;
      m_unf = 1'b0;
      return;
    end
    plus4 = m_pc + 32'd4;
    unf   = 1'b0;
    flow  = (s <= 3'd4);
    case (s)
      3'd0: nxt = plus4;
      3'd1: nxt = bt;
      3'd2: nxt = jt;
      3'd3: nxt = rt;
      3'd4: begin
        if (m_ras.size() > 0) nxt = m_ras[m_ras.size()-1];
        else begin nxt = rt; unf = 1'b1; end
      end
      3'd5: nxt = EXC;
      default: nxt = m_pc;
    endcase
    if (s == 3'd4 && m_ras.size() > 0) void'(m_ras.pop_back());
    if (c && flow) begin
      m_ras.push_back(plus4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    mis = flow && (nxt[1:0] != 2'b00);
    if (s == 3'd5 || mis) begin
      m_epc = m_pc;
      m_pc  = EXC;
    end else begin
      m_pc = nxt;
    end
    m_mis = mis;
    m_unf = unf;
  endtask

  task automatic check_all();
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("epc", epc, m_epc);
    check_eq("misaligned", 32'(misaligned), 32'(m_mis));
    check_eq("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    check_eq("ras_count", 32'(ras_count), 32'(m_ras.size()));
  endtask

  task automatic apply(input logic w, input logic [2:0] s, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] rt, input logic c);
    pc_write      = w;
    pc_src        = s;
    branch_target = bt;
    jump_target   = jt;
    reg_target    = rt;
    call          = c;
    @(posedge clock);
    #1;
    model_step(w, s, bt, jt, rt, c);
    check_all();
  endtask

  task automatic jump_to(input logic [31:0] t, input logic c);
    apply(1'b1, 3'(SRC_JUMP), 32'h0, t, 32'h0, c);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0:       return r;
      1:       return 32'hFFFF_FFFC;
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  initial begin
    reset         = 1'b1;
    pc_write      = 1'b0;
    pc_src        = 3'(SRC_SEQ);
    branch_target = '0;
    jump_target   = '0;
    reg_target    = '0;
    call          = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b0;

    // Sequential fetch then a stalled cycle.
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("seq_4", pc, 32'h4);
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("seq_c", pc, 32'hC);
    apply(1'b0, 3'(SRC_JUMP), 0, 32'h400, 0, 1'b1);
    check_eq("hold_c", pc, 32'hC);

    // Call and return.
    jump_to(32'h100, 1'b0);
    jump_to(32'h400, 1'b1);
    check_eq("call_pc", pc, 32'h400);
    check_eq("call_cnt", 32'(ras_count), 32'd1);
    apply(1'b1, 3'(SRC_RET), 0, 0, 0, 1'b0);
    check_eq("ret_pc", pc, 32'h104);
    check_eq("ret_cnt", 32'(ras_count), 32'd0);

    // Overfill the stack, drain it, then underflow.
    jump_to(32'h10, 1'b0);
    for (int i = 2; i <= 6; i++) jump_to(32'(i) << 4, 1'b1);
    check_eq("full_cnt", 32'(ras_count), 32'd4);
    for (int i = 5; i >= 2; i--) begin
      apply(1'b1, 3'(SRC_RET), 0, 0, 0, 1'b0);
      check_eq("drain_pc", pc, (32'(i) << 4) + 32'h4);
    end
    apply(1'b1, 3'(SRC_RET), 0, 0, 32'h800, 1'b0);
    check_eq("unf_pc", pc, 32'h800);
    check_eq("unf_pulse", 32'(ras_underflow), 32'd1);
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("unf_clear", 32'(ras_underflow), 32'd0);

    // Misaligned branch redirect.
    jump_to(32'h200, 1'b0);
    apply(1'b1, 3'(SRC_BRANCH), 32'h202, 0, 0, 1'b0);
    check_eq("mis_pc", pc, 32'h180);
    check_eq("mis_epc", epc, 32'h200);
    check_eq("mis_pulse", 32'(misaligned), 32'd1);
    apply(1'b0, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("mis_clear", 32'(misaligned), 32'd0);

    // Wrap and exception.
    jump_to(32'hFFFF_FFFC, 1'b0);
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("wrap_pc", pc, 32'h0);
    jump_to(32'h40, 1'b1);
    apply(1'b1, 3'(SRC_EXC), 0, 0, 0, 1'b1);
    check_eq("exc_pc", pc, 32'h180);
    check_eq("exc_epc", epc, 32'h40);
    check_eq("exc_cnt", 32'(ras_count), 32'd1);

    // RET and call together on an empty stack.
    apply(1'b1, 3'(SRC_RET), 0, 0, 32'h300, 1'b0);
    apply(1'b1, 3'(SRC_RET), 0, 0, 32'h500, 1'b1);
    check_eq("retcall_cnt", 32'(ras_count), 32'd1);

    // Reset asserted while a call/jump update is pending.
    pc_write    = 1'b1;
    pc_src      = 3'(SRC_JUMP);
    jump_target = 32'h900;
    call        = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_cnt", 32'(ras_count), 32'd0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    pc_write = 1'b0;
    check_all();
    apply(1'b1, 3'(SRC_SEQ), 0, 0, 0, 1'b0);
    check_eq("post_rst", pc, 32'h4);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            rand_target(), rand_target(), rand_target(),
            ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
